// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the M-extension sequencer.
// The pipeline drives the op and kill; the sequencer returns stall, busy, done and result.
interface muldiv_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  StartC;
  logic [2:0]            Funct3C;
  logic [DATA_WIDTH-1:0] OpAC;
  logic [DATA_WIDTH-1:0] OpBC;
  logic                  KillH;
  logic                  StallH;
  logic                  BusyC;
  logic                  DoneC;
  logic [DATA_WIDTH-1:0] ResultC;

  modport master (
    output StartC, Funct3C, OpAC, OpBC, KillH,
    input  StallH, BusyC, DoneC, ResultC
  );

  modport slave (
    input  StartC, Funct3C, OpAC, OpBC, KillH,
    output StallH, BusyC, DoneC, ResultC
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide controller for the execute stage.
// The shift-add multiply and the restoring divide share one 2*DATA_WIDTH accumulator.
module muldiv_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  muldiv_sequencer_if.slave bus
);
  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [W-1:0]    b_q, b_d;
  logic            neg_q, neg_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    stage_q, stage_d;
  logic [W-1:0]    result_q, result_d;

  // Acceptance-time decode of the incoming op
  logic         is_div, sign_a, sign_b, neg_a, neg_b, div_zero, overflow, res_neg;
  logic [W-1:0] mag_a, mag_b, fast_res;

  assign is_div   = bus.Funct3C[2];
  assign sign_a   = is_div ? ~bus.Funct3C[0] : (bus.Funct3C == 3'b001 || bus.Funct3C == 3'b010);
  assign sign_b   = is_div ? ~bus.Funct3C[0] : (bus.Funct3C == 3'b001);
  assign neg_a    = sign_a & bus.OpAC[W-1];
  assign neg_b    = sign_b & bus.OpBC[W-1];
  assign mag_a    = neg_a ? -bus.OpAC : bus.OpAC;
  assign mag_b    = neg_b ? -bus.OpBC : bus.OpBC;
  assign div_zero = is_div & (bus.OpBC == '0);
  assign overflow = is_div & ~bus.Funct3C[0] & (bus.OpAC == {1'b1, {(W-1){1'b0}}}) & (&bus.OpBC);
  assign fast_res = div_zero ? (bus.Funct3C[1] ? bus.OpAC : {W{1'b1}})
                             : (bus.Funct3C[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}});
  // Quotient takes sA^sB, remainder takes sA, unsigned divides never negate
  assign res_neg  = is_div ? (~bus.Funct3C[0] & (bus.Funct3C[1] ? neg_a : (neg_a ^ neg_b)))
                           : (neg_a ^ neg_b);

  // One iteration of each algorithm
  logic [W:0]     mul_sum, div_rem_sh, div_diff;
  logic [2*W-1:0] mul_next, div_next;

  assign mul_sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
  assign mul_next   = {mul_sum, acc_q[W-1:1]};
  assign div_rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff   = div_rem_sh - {1'b0, b_q};
  assign div_next   = div_diff[W] ? {div_rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

  // Sign correction and result selection
  logic [2*W-1:0] prod_fixed;
  logic [W-1:0]   div_raw, div_fixed, fix_res;

  assign prod_fixed = neg_q ? -acc_q : acc_q;
  assign div_raw    = funct3_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
  assign div_fixed  = neg_q ? -div_raw : div_raw;
  assign fix_res    = funct3_q[2] ? div_fixed
                    : (funct3_q == 3'b000) ? prod_fixed[W-1:0] : prod_fixed[2*W-1:W];

  // A kill landing on the DONE cycle suppresses the completion and the result update
  assign bus.DoneC   = (state_q == StDone) & ~bus.KillH;
  assign bus.ResultC = bus.DoneC ? stage_q : result_q;
  assign bus.StallH  = bus.StartC & ~bus.DoneC & ~bus.KillH;
  assign bus.BusyC   = (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    b_d      = b_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    stage_d  = stage_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.StartC && !bus.KillH) begin
          funct3_d = bus.Funct3C;
          b_d      = mag_b;
          neg_d    = res_neg;
          cnt_d    = '0;
          acc_d    = {{W{1'b0}}, mag_a};
          if (div_zero || overflow) begin
            stage_d = fast_res;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (bus.KillH) begin
          state_d = StIdle;
        end else begin
          acc_d = funct3_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(W - 1)) state_d = StFix;
        end
      end
      StFix: begin
        if (bus.KillH) begin
          state_d = StIdle;
        end else begin
          stage_d = fix_res;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!bus.KillH) result_d = stage_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      funct3_q <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      stage_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      stage_q  <= stage_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, kill, reset and latency checks.
module tb_muldiv_sequencer;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.DATA_WIDTH(W)) bus ();

  muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completion pops the oldest expected result
  always @(negedge clk) begin
    if (bus.DoneC === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DoneC=1 with ResultC %h, expected no completion",
                 bus.ResultC);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", bus.ResultC, mon_exp);
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    bus.StartC  = 1'b1;
    bus.Funct3C = f;
    bus.OpAC    = a;
    bus.OpBC    = b;
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int n = 0;
    int stalls = 0;
    bit done = 0;
    drive(f, a, b);
    exp_q.push_back(exp);
    while (!done && n < 100) begin
      @(negedge clk);
      if (bus.DoneC === 1'b1) begin
        done = 1;
      end else begin
        if (bus.StallH === 1'b1) stalls++;
        n++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no DoneC in %0d cycles, expected %0d", name, n, lat);
    end else begin
      check({name, "_latency"}, W'(n), W'(lat));
      check({name, "_stalls"}, W'(stalls), W'(lat));
      check({name, "_stall_at_done"}, W'(bus.StallH), '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.StartC  = 1'b0;
    bus.Funct3C = 3'b000;
    bus.OpAC    = '0;
    bus.OpBC    = '0;
    bus.KillH   = 1'b0;
    #12;
    check("rst_busy", W'(bus.BusyC), '0);
    check("rst_done", W'(bus.DoneC), '0);
    check("rst_result", bus.ResultC, '0);
    check("rst_stall_idle", W'(bus.StallH), '0);
    bus.StartC = 1'b1;
    #1;
    check("rst_stall_follows_start", W'(bus.StallH), W'(1));
    bus.StartC = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Kill together with start in IDLE: dropped, no stall
    @(posedge clk);
    #1;
    bus.StartC = 1'b1;
    bus.KillH  = 1'b1;
    bus.OpAC   = 32'd3;
    bus.OpBC   = 32'd4;
    @(negedge clk);
    check("kill_start_stall", W'(bus.StallH), '0);
    @(posedge clk);
    #1;
    check("kill_start_busy", W'(bus.BusyC), '0);
    bus.StartC = 1'b0;
    bus.KillH  = 1'b0;

    // Back-to-back directed vectors
    run_op("mul",        3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulh",       3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("mulhu",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("divu_zero",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_zero",   3'b110, 32'd5,         32'd0,         32'd5,         1);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("div",        3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem",        3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu",       3'b101, 32'd100,       32'd7,         32'd14,        34);
    run_op("remu",       3'b111, 32'd100,       32'd7,         32'd2,         34);
    @(posedge clk);
    #1;
    bus.StartC = 1'b0;
    @(negedge clk);
    check("idle_after_done_busy", W'(bus.BusyC), '0);
    check("result_held", bus.ResultC, 32'd2);

    // Kill mid-divide around iteration 10
    drive(3'b100, 32'hFFFF_FFF9, 32'd2);
    repeat (10) @(posedge clk);
    #1;
    bus.KillH  = 1'b1;
    bus.StartC = 1'b0;
    @(negedge clk);
    check("kill_done_low", W'(bus.DoneC), '0);
    check("kill_stall_low", W'(bus.StallH), '0);
    @(posedge clk);
    #1;
    bus.KillH = 1'b0;
    @(negedge clk);
    check("kill_busy_low", W'(bus.BusyC), '0);
    check("kill_result_kept", bus.ResultC, 32'd2);
    repeat (40) @(negedge clk);
    run_op("mul_after_kill", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    // Asynchronous reset mid-multiply
    drive(3'b011, 32'hFFFF_FFFF, 32'd2);
    repeat (21) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", W'(bus.BusyC), '0);
    check("midrst_done", W'(bus.DoneC), '0);
    check("midrst_result", bus.ResultC, '0);
    check("midrst_stall", W'(bus.StallH), W'(1));
    bus.StartC = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mulhu_after_rst", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, 34);
    @(posedge clk);
    #1;
    bus.StartC = 1'b0;
    repeat (40) @(negedge clk);
    check("queue_empty", W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for RV32M multiply/divide instructions resolved in the execute (C) stage. It captures forwarded operands when an M-extension op reaches execute and runs an iterative shift-add multiply or restoring divide over DATA_WIDTH cycles. While it works, it holds the front of the pipeline through a stall request to the hazard unit. On completion it presents a one-cycle result that the execute stage muxes into its ALU result path.

## Interface
- DATA_WIDTH, 32, operand/result width; must be a multiple of 8.
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; one clock domain; asynchronous assert, active-low.
- StartC  in  1  M-extension op is valid in execute this cycle.
- Funct3C  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OpAC  in  DATA_WIDTH  rs1 value after forwarding mux.
- OpBC  in  DATA_WIDTH  rs2 value after forwarding mux.
- KillH  in  1  abort the in-flight op and drop any op presented this cycle.
- StallH  out  1  hold F/D/C stage registers; combinational.
- BusyC  out  1  state != IDLE.
- DoneC  out  1  result valid; high exactly one cycle per completed op.
- ResultC  out  DATA_WIDTH  result; holds its value until the next completion.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - StartC=1 and KillH=0 at an edge: accept; latch Funct3C, OpAC, OpBC.
  - Normal case: go to CALC with the iteration counter at 0.
  - Divide by zero or signed overflow: take the fast path to DONE.
- CALC: one iteration per edge. After DATA_WIDTH iterations, go to FIX.
- FIX: apply sign correction, register ResultC, go to DONE.
- DONE: DoneC=1; next edge goes to IDLE.
- StallH = StartC & ~DoneC & ~KillH. The stalled instruction advances on the DONE cycle, so a following M op is presented fresh in IDLE.
- Operand signedness:
  - Signed: MULH both operands; MULHSU operand A only; DIV and REM both.
  - Convert signed operands to magnitudes at acceptance.
- Multiply: 2·DATA_WIDTH accumulator.
  - Result sign = sA ^ sB, negated in FIX.
  - MUL returns the low half; the others return the high half.
- Divide: restoring, one quotient bit per cycle.
  - Quotient sign = sA ^ sB; remainder sign = sA.
  - DIVU/REMU never negate.
- Divide by zero: quotient = all ones; remainder = OpAC.
- Signed overflow (DIV/REM, OpAC = 0x8000_0000, OpBC = all ones): quotient = 0x8000_0000; remainder = 0.
- KillH=1 in CALC, FIX or DONE: next edge goes to IDLE. DoneC stays low, ResultC is unchanged, and any partial result is discarded.
- Operand changes after acceptance are ignored.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, counter 0, StallH follows StartC (it is combinational), BusyC=0, DoneC=0, ResultC=0, latched operands 0.
- Reset mid-operation aborts immediately; no DoneC.
- Normal latency: accepting edge E0 → CALC. Iterations happen at edges E1..E(DATA_WIDTH); edge E(DATA_WIDTH) → FIX. Edge E(DATA_WIDTH+1) → DONE.
  - DoneC is high in the cycle after E(DATA_WIDTH+1): 34 cycles of StallH at DATA_WIDTH=32.
- Fast path: E0 → DONE; DoneC is high in the cycle after E0, giving 1 stall cycle.
- BusyC rises after E0 and falls after the DONE cycle's edge.
- Back-to-back: a new StartC in the cycle after DONE is accepted with no bubble.
- KillH and StartC together in IDLE: no acceptance; StallH=0.

## Test plan
- MUL 7 × 0xFFFF_FFFD (-3) → ResultC=0xFFFF_FFEB; DoneC exactly 34 cycles after StartC rises; StallH high for 34 cycles.
- MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000. MULHSU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFF. MULHU same operands → 0xFFFF_FFFE.
- DIV -7/2 → 0xFFFF_FFFD; REM -7/2 → 0xFFFF_FFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFF_FFFF; REM 5/0 → 5; DIV 0x8000_0000/-1 → 0x8000_0000; REM of the same operands → 0. Each completes with DoneC one cycle after acceptance.
- Start DIV, assert KillH for one cycle at iteration 10 → BusyC=0 next cycle, no DoneC, ResultC keeps its prior value. A following MUL 3×4 → 12.
- Drop rst_n at iteration 20 → all outputs at reset values immediately. After release, a fresh MULHU 0xFFFF_FFFF×2 → 1.
